// File: rtl/bufg_gt_ctrl_pkg.sv
// Shared types and widths for the BUFG_GT divide-change controller.
package bufg_gt_ctrl_pkg;

    localparam int TMR_W = 8;
    localparam int DIV_W = 3;

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_QUIESCE  = 3'd1,
        ST_CLEAR    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_ENABLE   = 3'd4,
        ST_IDLE     = 3'd5
    } state_t;

endpackage

// File: rtl/bufg_gt_ctrl_tmr.sv
// Loadable down-counter that holds at zero and flags it; times each controller phase.
module bufg_gt_ctrl_tmr
    import bufg_gt_ctrl_pkg::*;
#(
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bufg_gt_div_ctrl.sv
// Sequences CE/CLR/DIV of a BUFG_GT so the divide ratio changes without runt clocks.
// Optional macro BUFG_GT_CTRL_PEND_EN: queue one request arriving while busy instead of dropping it.
module bufg_gt_div_ctrl
    import bufg_gt_ctrl_pkg::*;
#(
    parameter int               QUIESCE_CYCLES = 2,
    parameter int               CLR_CYCLES     = 4,
    parameter int               SETTLE_CYCLES  = 8,
    parameter logic [DIV_W-1:0] DIV_INIT       = 3'd0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ,
    input  logic [DIV_W-1:0] REQ_DIV,
    output logic             ACK,
    output logic             BUSY,
    output logic             REQ_DROP,
    output logic             GT_CE,
    output logic             GT_CLR,
    output logic [DIV_W-1:0] GT_DIV,
    output logic [DIV_W-1:0] CUR_DIV
);

    localparam logic [TMR_W-1:0] QUIESCE_LD = TMR_W'(QUIESCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLR_LD     = TMR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             in_init;
    logic [DIV_W-1:0] cap_div;
    logic [DIV_W-1:0] next_div;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             req_idle;
    logic             req_new;
    logic             req_same;
    logic             req_busy;
    logic             chain_new;
    logic             chain_same;
    logic             drop_nxt;

    assign req_idle = REQ && (state == ST_IDLE);
    assign req_new  = req_idle && (REQ_DIV != CUR_DIV);
    assign req_same = req_idle && (REQ_DIV == CUR_DIV);
    assign req_busy = REQ && (state != ST_IDLE);

`ifdef BUFG_GT_CTRL_PEND_EN
    logic             pend_vld;
    logic [DIV_W-1:0] pend_div;
    logic             eff_vld;
    logic [DIV_W-1:0] eff_div;

    // A request sampled in ENABLE itself is folded straight into the exit decision.
    assign eff_vld    = pend_vld || req_busy;
    assign eff_div    = req_busy ? REQ_DIV : pend_div;
    assign chain_new  = (state == ST_ENABLE) && eff_vld && (eff_div != CUR_DIV);
    assign chain_same = (state == ST_ENABLE) && eff_vld && (eff_div == CUR_DIV);
    assign next_div   = (state == ST_ENABLE) ? eff_div : REQ_DIV;
    assign drop_nxt   = req_busy && pend_vld;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_vld <= 1'b0;
        end else if (state == ST_ENABLE) begin
            pend_vld <= 1'b0;
        end else if (req_busy) begin
            pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (req_busy && (state != ST_ENABLE)) begin
            pend_div <= REQ_DIV;
        end
    end
`else
    assign chain_new  = 1'b0;
    assign chain_same = 1'b0;
    assign next_div   = REQ_DIV;
    assign drop_nxt   = req_busy;
`endif

    bufg_gt_ctrl_tmr #(
        .RST_VAL (CLR_LD)
    ) u_tmr (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = QUIESCE_LD;
        case (state)
            ST_INIT_CLR, ST_CLEAR: begin
                if (tmr_zero) begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LD;
                end
            end
            ST_QUIESCE: begin
                if (tmr_zero) begin
                    state_nxt = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_val   = CLR_LD;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (chain_new) begin
                    state_nxt = ST_QUIESCE;
                    tmr_load  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_new) begin
                    state_nxt = ST_QUIESCE;
                    tmr_load  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT_CLR;
                tmr_load  = 1'b1;
                tmr_val   = CLR_LD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (req_new || chain_new) begin
            cap_div <= next_div;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_INIT_CLR;
            in_init  <= 1'b1;
            GT_CE    <= 1'b0;
            GT_CLR   <= 1'b1;
            GT_DIV   <= DIV_INIT;
            CUR_DIV  <= DIV_INIT;
            ACK      <= 1'b0;
            REQ_DROP <= 1'b0;
            BUSY     <= 1'b1;
        end else begin
            state    <= state_nxt;
            BUSY     <= (state_nxt != ST_IDLE);
            REQ_DROP <= drop_nxt;
            ACK      <= req_same || chain_same ||
                        ((state == ST_SETTLE) && (state_nxt == ST_ENABLE) && !in_init);
            if (state == ST_ENABLE) begin
                in_init <= 1'b0;
            end
            if (state_nxt == ST_QUIESCE) begin
                GT_CE <= 1'b0;
            end
            // The new divide code is presented only while the buffer is held in clear.
            if ((state == ST_QUIESCE) && (state_nxt == ST_CLEAR)) begin
                GT_CLR <= 1'b1;
                GT_DIV <= cap_div;
            end
            if (state_nxt == ST_SETTLE) begin
                GT_CLR <= 1'b0;
            end
            if ((state == ST_SETTLE) && (state_nxt == ST_ENABLE)) begin
                GT_CE <= 1'b1;
                if (!in_init) begin
                    CUR_DIV <= cap_div;
                end
            end
        end
    end

endmodule

// File: tb/tb_bufg_gt_div_ctrl.sv
// Scoreboard bench for bufg_gt_div_ctrl at default parameters.
module tb_bufg_gt_div_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       REQ;
    logic [2:0] REQ_DIV;
    logic       ACK;
    logic       BUSY;
    logic       REQ_DROP;
    logic       GT_CE;
    logic       GT_CLR;
    logic [2:0] GT_DIV;
    logic [2:0] CUR_DIV;

    bufg_gt_div_ctrl dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .REQ      (REQ),
        .REQ_DIV  (REQ_DIV),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .REQ_DROP (REQ_DROP),
        .GT_CE    (GT_CE),
        .GT_CLR   (GT_CLR),
        .GT_DIV   (GT_DIV),
        .CUR_DIV  (CUR_DIV)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Row vector: {GT_CE, GT_CLR, GT_DIV, CUR_DIV, ACK, BUSY, REQ_DROP}
    typedef struct {
        int          cyc;
        logic [10:0] v;
    } row_t;

    typedef struct {
        int         cyc;
        logic [2:0] div;
    } ev_t;

    row_t rows[$];
    ev_t  acks[$];
    ev_t  drops[$];
    int   cyc   = 0;
    int   nchk  = 0;
    int   npass = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [10:0] pk(bit ce, bit clr, logic [2:0] gd, logic [2:0] cd,
                                       bit ack, bit busy, bit drop);
        return {ce, clr, gd, cd, ack, busy, drop};
    endfunction

    task automatic push_row(int c, logic [10:0] v);
        row_t r;
        r.cyc = c;
        r.v   = v;
        rows.push_back(r);
    endtask

    task automatic push_ev(bit is_ack, int c, logic [2:0] d);
        ev_t e;
        e.cyc = c;
        e.div = d;
        if (is_ack) acks.push_back(e);
        else        drops.push_back(e);
    endtask

    // Expected INIT sequence starting at the cycle in which reset is released.
    task automatic push_init(int b);
        for (int i = 0; i < 14; i++)
            push_row(b + i, pk(i >= 12, i < 4, 3'd0, 3'd0, 1'b0, i != 13, 1'b0));
    endtask

    // Expected change sequence for a request accepted at edge k.
    task automatic push_seq(int k, logic [2:0] og, logic [2:0] oc, logic [2:0] nd,
                            int last, int drop_at);
        logic [2:0] gd;
        logic [2:0] cd;
        for (int i = 0; i < 16; i++) begin
            gd = (i < 2)  ? og : nd;
            cd = (i < 14) ? oc : nd;
            if (k + i <= last)
                push_row(k + i, pk(i >= 14, (i >= 2) && (i < 6), gd, cd, i == 14, i != 15,
                                   (k + i) == drop_at));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) step();
    endtask

    always @(negedge CLK) begin : mon
        logic [10:0] act;
        row_t        r;
        ev_t         e;
        act = {GT_CE, GT_CLR, GT_DIV, CUR_DIV, ACK, BUSY, REQ_DROP};
        while (rows.size() > 0 && rows[0].cyc <= cyc) begin
            r = rows.pop_front();
            nchk++;
            if (r.cyc != cyc)
                $display("FAIL row_missed: expected cycle %0d, now at cycle %0d", r.cyc, cyc);
            else if (act !== r.v)
                $display("FAIL outputs cyc=%0d: got ce/clr/gdiv/cdiv/ack/busy/drop=%b required %b",
                         cyc, act, r.v);
            else
                npass++;
        end
        if (ACK === 1'b1) begin
            nchk++;
            if (acks.size() == 0) begin
                $display("FAIL ack_unexpected cyc=%0d: got ACK=1 CUR_DIV=%0d required no ACK",
                         cyc, CUR_DIV);
            end else begin
                e = acks.pop_front();
                if (e.cyc == cyc && CUR_DIV === e.div)
                    npass++;
                else
                    $display("FAIL ack_event: got cycle %0d CUR_DIV=%0d required cycle %0d CUR_DIV=%0d",
                             cyc, CUR_DIV, e.cyc, e.div);
            end
        end
        if (REQ_DROP === 1'b1) begin
            nchk++;
            if (drops.size() == 0) begin
                $display("FAIL drop_unexpected cyc=%0d: got REQ_DROP=1 required 0", cyc);
            end else begin
                e = drops.pop_front();
                if (e.cyc == cyc)
                    npass++;
                else
                    $display("FAIL drop_event: got cycle %0d required cycle %0d", cyc, e.cyc);
            end
        end
        nchk++;
        if (GT_CE === 1'b1 && GT_CLR === 1'b1)
            $display("FAIL ce_clr_exclusive cyc=%0d: got CE=1 CLR=1 required not both", cyc);
        else
            npass++;
    end

    initial begin : stim
        int k;
        int b;
        RST_N   = 1'b0;
        REQ     = 1'b0;
        REQ_DIV = 3'd0;

        // Reset state, then release and expect the INIT sequence without ACK.
        push_row(1, pk(0, 1, 3'd0, 3'd0, 0, 1, 0));
        push_row(2, pk(0, 1, 3'd0, 3'd0, 0, 1, 0));
        wait_until(3);
        RST_N = 1'b1;
        b = cyc;
        push_init(b);
        wait_until(b + 14);

        // Full change to code 3.
        k = cyc + 1;
        REQ = 1'b1;
        REQ_DIV = 3'd3;
        push_seq(k, 3'd0, 3'd0, 3'd3, k + 15, -1);
        push_ev(1'b1, k + 14, 3'd3);
        step();
        REQ = 1'b0;
        wait_until(k + 16);

        // Same-value fast path, single cycle.
        k = cyc + 1;
        REQ = 1'b1;
        REQ_DIV = 3'd3;
        push_row(k, pk(1, 0, 3'd3, 3'd3, 1, 0, 0));
        push_row(k + 1, pk(1, 0, 3'd3, 3'd3, 0, 0, 0));
        push_ev(1'b1, k, 3'd3);
        step();
        REQ = 1'b0;
        wait_until(k + 2);

        // Same value held for three cycles re-pulses ACK each cycle.
        k = cyc + 1;
        REQ = 1'b1;
        REQ_DIV = 3'd3;
        for (int i = 0; i < 3; i++) begin
            push_row(k + i, pk(1, 0, 3'd3, 3'd3, 1, 0, 0));
            push_ev(1'b1, k + i, 3'd3);
        end
        push_row(k + 3, pk(1, 0, 3'd3, 3'd3, 0, 0, 0));
        repeat (3) step();
        REQ = 1'b0;
        wait_until(k + 4);

        // Reset pulsed during SETTLE aborts the change to 6.
        k = cyc + 1;
        REQ = 1'b1;
        REQ_DIV = 3'd6;
        push_seq(k, 3'd3, 3'd3, 3'd6, k + 7, -1);
        step();
        REQ = 1'b0;
        wait_until(k + 8);
        RST_N = 1'b0;
        push_row(k + 8, pk(0, 1, 3'd0, 3'd0, 0, 1, 0));
        step();
        RST_N = 1'b1;
        b = cyc;
        push_init(b);
        wait_until(b + 14);

        // Request 3, then a request for 5 arrives during CLEAR.
        k = cyc + 1;
        REQ = 1'b1;
        REQ_DIV = 3'd3;
`ifdef BUFG_GT_CTRL_PEND_EN
        push_seq(k, 3'd0, 3'd0, 3'd3, k + 14, -1);
`else
        push_seq(k, 3'd0, 3'd0, 3'd3, k + 15, k + 3);
        push_ev(1'b0, k + 3, 3'd5);
`endif
        push_ev(1'b1, k + 14, 3'd3);
        step();
        REQ = 1'b0;
        wait_until(k + 2);
        REQ = 1'b1;
        REQ_DIV = 3'd5;
        step();
        REQ = 1'b0;
`ifdef BUFG_GT_CTRL_PEND_EN
        push_seq(k + 15, 3'd3, 3'd3, 3'd5, k + 30, -1);
        push_ev(1'b1, k + 29, 3'd5);
        wait_until(k + 31);
`else
        wait_until(k + 16);
`endif

        repeat (3) step();
        nchk++;
        if (rows.size() == 0) npass++;
        else $display("FAIL rows_left: got %0d unchecked rows required 0", rows.size());
        nchk++;
        if (acks.size() == 0) npass++;
        else $display("FAIL acks_missing: got %0d outstanding ACKs required 0", acks.size());
        nchk++;
        if (drops.size() == 0) npass++;
        else $display("FAIL drops_missing: got %0d outstanding drops required 0", drops.size());

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
